// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 constants, FSM states and access-size decode shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, WRITE, DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;
  // Loads and stores share one rule: funct3[1:0] 00 = byte, 01 = half, anything else = word.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0] ? SZ_B : f3[1:0] == F3_H[1:0] ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load lane extract/extend and store lane merge
// Ports: rdata/offset/funct3 -> load_data (extended load result);
//        old_word/wdata/offset/size -> merged (old word with addressed lane(s) replaced).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  lsu_size_e   size,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] mask;
  logic        sgn;
  lsu_size_e   lsize;
  always_comb begin
    sh        = {offset, 3'b000};
    lane8     = 8'(rdata >> sh);
    lane16    = 16'(rdata >> sh);
    lsize     = f3_size(funct3);
    sgn       = funct3 != F3_BU && funct3 != F3_HU;
    load_data = lsize == SZ_B ? {{24{sgn & lane8[7]}}, lane8} :
                lsize == SZ_H ? {{16{sgn & lane16[15]}}, lane16} : rdata;
    mask      = size == SZ_B ? 32'h0000_00ff << sh :
                size == SZ_H ? 32'h0000_ffff << sh : 32'hffff_ffff;
    merged    = (old_word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a 1-cycle registered word memory
// Ports: lsu_* request side (start/we/funct3/addr/wdata in; rdata/busy/done out),
//        mem_* memory side (word addr, write data, write enable out; registered read data in).
// Macro LSU_MISALIGN_TRAP_EN adds lsu_misaligned and traps misaligned H/W requests;
// without it low address bits are forced to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int LSU_ADDR_W = 32
) (
  input  logic                  lsu_clk,
  input  logic                  lsu_rst,
  input  logic                  lsu_start,
  input  logic                  lsu_we,
  input  logic [2:0]            lsu_funct3,
  input  logic [LSU_ADDR_W-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_busy,
  output logic                  lsu_done,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  lsu_misaligned,
`endif
  output logic [LSU_ADDR_W-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wr_en,
  input  logic [31:0]           mem_rdata
);
  lsu_state_e  state, next_state;
  lsu_size_e   start_size, req_size;
  logic [1:0]  start_off, req_off;
  logic [2:0]  req_f3;
  logic        req_we, trap, accept, store_word;
  logic [31:0] load_data, merged;
  assign start_size = f3_size(lsu_funct3);
  assign start_off  = start_size == SZ_W ? 2'b00 :
                      start_size == SZ_H ? {lsu_addr[1], 1'b0} : lsu_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = (start_size == SZ_H && lsu_addr[0]) || (start_size == SZ_W && lsu_addr[1:0] != 2'b00);
  assign lsu_misaligned = lsu_done & mis_q;
  always_ff @(posedge lsu_clk)
    if (lsu_rst) mis_q <= 1'b0;
    else if (accept) mis_q <= trap;
`else
  assign trap = 1'b0;
`endif
  assign accept     = state == IDLE && lsu_start;
  assign store_word = req_we && req_size == SZ_W;
  assign lsu_busy   = state != IDLE;
  assign lsu_done   = state == DONE;
  assign mem_wr_en  = (state == ACCESS && store_word) || state == WRITE;
  always_ff @(posedge lsu_clk)
    if (lsu_rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = lsu_start ? (trap ? DONE : ACCESS) : IDLE;
      ACCESS:  next_state = store_word ? DONE : CAPTURE;
      CAPTURE: next_state = req_we ? WRITE : DONE;
      WRITE:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end
  // mem_wdata doubles as the latched store data until CAPTURE overwrites it with the merged word.
  always_ff @(posedge lsu_clk)
    if (lsu_rst) begin
      req_we    <= 1'b0;
      req_f3    <= 3'b000;
      req_size  <= SZ_B;
      req_off   <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lsu_rdata <= '0;
    end else begin
      if (accept) begin
        req_we   <= lsu_we;
        req_f3   <= lsu_funct3;
        req_size <= start_size;
        req_off  <= start_off;
        if (!trap) begin
          mem_addr <= lsu_addr[LSU_ADDR_W-1:2];
          if (lsu_we) mem_wdata <= lsu_wdata;
        end
      end
      if (state == CAPTURE) begin
        if (req_we) mem_wdata <= merged;
        else lsu_rdata <= load_data;
      end
    end
  lsu_lane_align u_align (
    .rdata    (mem_rdata),
    .offset   (req_off),
    .funct3   (req_f3),
    .old_word (mem_rdata),
    .wdata    (mem_wdata),
    .size     (req_size),
    .load_data(load_data),
    .merged   (merged)
  );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a 1-cycle registered memory model
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, we = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic        busy, done, wr_en, mis;
  logic [31:0] mem [0:255];
  int compared = 0, mismatched = 0, wr_count = 0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .lsu_clk       (clk),
    .lsu_rst       (rst),
    .lsu_start     (start),
    .lsu_we        (we),
    .lsu_funct3    (f3),
    .lsu_addr      (addr),
    .lsu_wdata     (wdata),
    .lsu_rdata     (rdata),
    .lsu_busy      (busy),
    .lsu_done      (done),
`ifdef LSU_MISALIGN_TRAP_EN
    .lsu_misaligned(mis),
`endif
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wr_en     (wr_en),
    .mem_rdata     (mem_rdata)
  );
`ifndef LSU_MISALIGN_TRAP_EN
  assign mis = 1'b0;
`endif
  always @(posedge clk) begin
    if (wr_en) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                    output int lat, output int wr_at, output logic [31:0] wd, output logic [29:0] wa,
                    output int wrs, output logic m);
    int w0;
    @(negedge clk);
    start = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    w0 = wr_count; wr_at = -1; wd = '0; wa = '0;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (wr_en) begin wr_at = lat; wd = mem_wdata; wa = mem_addr; end
      @(posedge clk); #1 lat++;
    end
    m = mis;
    @(posedge clk); #1 wrs = wr_count - w0;
  endtask
  logic [31:0] la [5] = '{32'h105, 32'h107, 32'h106, 32'h106, 32'h106};
  logic [2:0]  lf [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] le [5] = '{32'h0000_007f, 32'hffff_ff80, 32'h0000_00ff, 32'hffff_80ff, 32'h0000_80ff};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, wr_at, wrs, w0, dn, first, second;
    logic [31:0] wd;
    logic [29:0] wa;
    logic m;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h41] = 32'h80ff_7f01;
    mem[8'h42] = 32'h1122_3344;
    mem[8'h43] = 32'h5566_7788;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_wr_en", {31'b0, wr_en}, 32'h0);
    check("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mis", {31'b0, mis}, 32'h0);
    @(negedge clk) rst = 1'b0;
    op(1'b1, 3'b010, 32'h100, 32'hdead_beef, lat, wr_at, wd, wa, wrs, m);
    check("sw_lat", lat, 2);
    check("sw_wr_at", wr_at, 1);
    check("sw_wr_addr", {2'b0, wa}, 32'h40);
    check("sw_wr_data", wd, 32'hdead_beef);
    check("sw_wr_pulses", wrs, 1);
    op(1'b0, 3'b010, 32'h100, 32'h0, lat, wr_at, wd, wa, wrs, m);
    check("lw_lat", lat, 3);
    check("lw_data", rdata, 32'hdead_beef);
    check("lw_no_write", wrs, 0);
    check("lw_idle_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, lf[i], la[i], 32'h0, lat, wr_at, wd, wa, wrs, m);
      check($sformatf("load%0d_data", i), rdata, le[i]);
      check($sformatf("load%0d_lat", i), lat, 3);
    end
    op(1'b1, 3'b000, 32'h109, 32'hffff_ffaa, lat, wr_at, wd, wa, wrs, m);
    check("sb_lat", lat, 4);
    check("sb_wr_at", wr_at, 3);
    check("sb_wr_data", wd, 32'h1122_aa44);
    check("sb_wr_pulses", wrs, 1);
    check("sb_mem", mem[8'h42], 32'h1122_aa44);
    mem[8'h42] = 32'h1122_3344;
    op(1'b1, 3'b001, 32'h10a, 32'h1234_beef, lat, wr_at, wd, wa, wrs, m);
    check("sh_lat", lat, 4);
    check("sh_wr_data", wd, 32'hbeef_3344);
    check("sh_wr_pulses", wrs, 1);
    op(1'b0, 3'b010, 32'h108, 32'h0, lat, wr_at, wd, wa, wrs, m);
    check("sh_readback", rdata, 32'hbeef_3344);
    @(negedge clk);
    start = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h110; wdata = 32'h0bad_f00d;
    w0 = wr_count; dn = 0; first = -1; second = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        if (first < 0) first = k;
        else second = k;
      end
      if (k == 5) start = 1'b0;
    end
    check("held_done_count", dn, 2);
    check("held_first_done", first, 2);
    check("held_second_done", second, 5);
    check("held_wr_pulses", wr_count - w0, 2);
    check("held_mem", mem[8'h44], 32'h0bad_f00d);
    op(1'b0, 3'b010, 32'h102, 32'h0, lat, wr_at, wd, wa, wrs, m);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat", lat, 1);
    check("mis_flag", {31'b0, m}, 32'h1);
    check("mis_no_write", wrs, 0);
    check("mis_rdata_kept", rdata, 32'hbeef_3344);
    check("mis_addr_kept", {2'b0, mem_addr}, 32'h44);
`else
    check("unaligned_lat", lat, 3);
    check("unaligned_data", rdata, 32'hdead_beef);
    check("unaligned_addr", {2'b0, mem_addr}, 32'h40);
    check("unaligned_flag", {31'b0, m}, 32'h0);
`endif
    @(negedge clk);
    start = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h10c; wdata = 32'h0000_0099;
    w0 = wr_count;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_wr_en", {31'b0, wr_en}, 32'h0);
    check("abort_mem_addr", {2'b0, mem_addr}, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_no_write", wr_count - w0, 0);
    @(negedge clk) rst = 1'b0;
    op(1'b0, 3'b010, 32'h10c, 32'h0, lat, wr_at, wd, wa, wrs, m);
    check("abort_readback", rdata, 32'h5566_7788);
    check("abort_mem", mem[8'h43], 32'h5566_7788);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory path. Accepts one load or store at a time from the execute stage, issues word-addressed accesses to the data memory, and returns sign- or zero-extended load data. The data memory has a registered 1-cycle read and word-only writes, so the block implements byte and halfword stores as read-modify-write sequences.

## Interface
- `LSU_ADDR_W`, default 32: byte-address width from the core.
- `lsu_clk` in 1: clock; all state updates on the rising edge.
- `lsu_rst` in 1: synchronous, active-high reset.
- `lsu_start` in 1: request strobe, sampled only in IDLE.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: store data; byte in [7:0], halfword in [15:0].
- `lsu_rdata` out 32: extended load result, held until the next load completes.
- `lsu_busy` out 1: high whenever state ≠ IDLE.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_misaligned` out 1: valid with `lsu_done`; exists only under the macro.
- `mem_addr` out 30: word address, `lsu_addr[31:2]`.
- `mem_wdata` out 32: write word.
- `mem_wr_en` out 1: write enable.
- `mem_rdata` in 32: registered read data; valid one cycle after `mem_addr` is presented.

## Operation
- States: IDLE, ACCESS, CAPTURE, WRITE, DONE.
- IDLE → ACCESS when `lsu_start` is high. The request is latched and `mem_addr` is registered.
- ACCESS:
  - SW: `mem_wr_en`=1 and `mem_wdata`=`lsu_wdata`, then → DONE.
  - Any other request: `mem_wr_en`=0, then → CAPTURE.
- CAPTURE: `mem_rdata` is valid.
  - Load: byte/half selected by `addr[1:0]` (little-endian: offset 0 = bits [7:0]). Sign-extend for B/H, zero-extend for BU/HU, W passes through. Result is registered into `lsu_rdata`. → DONE.
  - SB/SH: the addressed lane(s) of `mem_rdata` are replaced with `lsu_wdata` low bits and the merged word is registered into `mem_wdata`. → WRITE.
- WRITE: `mem_wr_en`=1 for exactly one cycle, same `mem_addr`. → DONE.
- DONE: `lsu_done`=1. → IDLE.
- Unlisted funct3 decoding:
  - Loads with 011/110/111 behave as LW.
  - Stores decode only funct3[1:0]: 00 = SB, 01 = SH, others = SW.
- `lsu_start` outside IDLE is ignored, including in the DONE cycle.
- `mem_wr_en` is never high outside ACCESS(SW) and WRITE.

## Timing
- Reset (synchronous): state IDLE; `mem_addr`, `mem_wdata`, and `lsu_rdata` = 0; `mem_wr_en`, `lsu_busy`, `lsu_done`, and `lsu_misaligned` = 0.
- Latency from the start cycle C0 to the `lsu_done` cycle:
  - SW: C2.
  - Loads: C3.
  - SB/SH: C4.
  - Misaligned trap: C1.
- Back-to-back: the earliest next accepted start is the cycle after DONE (IDLE).
- `lsu_rdata` updates at the CAPTURE→DONE edge, so it is valid when `lsu_done` is high.
- Reset asserted mid-operation: the sequence aborts to IDLE at that edge. If the reset edge ends an ACCESS(SW) or WRITE cycle, the memory write at that edge still occurs. A reset edge ending CAPTURE of SB/SH produces no write.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misalignment is H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - A misaligned request goes IDLE→DONE with `lsu_misaligned`=1 and `lsu_done`=1 at C1.
  - No memory access is made and `lsu_rdata` is unchanged.
- Undefined: the `lsu_misaligned` port is absent. Low address bits are forced to natural alignment (H ignores bit 0, W ignores bits [1:0]) and the access proceeds normally.

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum.
- Sub-module `lsu_lane_align`, purely combinational:
  - Load extract/extend: inputs rdata, offset, funct3.
  - Store merge: inputs old word, wdata, offset, size.
- Everything else, including the FSM, lives in `load_store_unit`.

## Test plan
Test addresses are ≥ 0x100 and the memory model is preloaded.
- SW 0xDEADBEEF @0x100 → `mem_wr_en` high at C1, `mem_addr`=0x40, `lsu_done` at C2. LW @0x100 then returns 0xDEADBEEF at C3.
- Word @0x104 = 0x80FF7F01:
  - LB @0x105 → 0x0000007F.
  - LB @0x107 → 0xFFFFFF80.
  - LBU @0x106 → 0x000000FF.
  - LH @0x106 → 0xFFFF80FF.
  - LHU @0x106 → 0x000080FF.
- Word @0x108 = 0x11223344:
  - SB 0xAA @0x109 → single write at C3 of 0x1122AA44, `lsu_done` at C4.
  - SH 0xBEEF @0x10A → 0xBEEF3344.
- `lsu_start` held high continuously → accepts only in IDLE. A second SW starts the cycle after DONE; exactly one `mem_wr_en` pulse per request.
- With `LSU_MISALIGN_TRAP_EN`, LW @0x102 → `lsu_done` and `lsu_misaligned` at C1, no memory activity. Without the macro, the same request reads word 0x40.
- `lsu_rst` asserted in the CAPTURE cycle of SB → no write occurs, next cycle all outputs are at reset values, and a following LW returns the unmodified word.
